seg_scan_controller: RTL and testbench

Time-multiplexing scan controller for the shared 8-digit seven-segment bus (E anodes, CA2G segments, dp). It owns the digit refresh schedule and snapshots the 8 hex nibbles supplied by the datapath. It drives one digit per slot, with an anti-ghosting blank interval at the start of each slot. It sits between the datapath's 32-bit display word and the board pins, replacing free-running ad-hoc refresh logic in Top_Level.

---
 rtl/seg_scan_controller.sv | 131 +++++++++++++
 tb/tb_seg_scan_controller.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// ============================================================================
// Module      : seg_scan_controller
// Description : Eight-digit seven-segment scan controller. Each digit gets one
//               slot of fixed length, starting with a blanking interval.
//               The optional macro SEG_LEADING_ZERO_BLANK_EN darkens leading
//               zero digits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  output logic [7:0]  E,
  output logic [6:0]  CA2G,
  output logic        dp,
  output logic [2:0]  digit_idx,
  output logic        frame_tick
);

  localparam int              c_cw         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cw-1:0] c_blank_last = c_cw'(BLANK_CYCLES - 1);
  localparam logic [c_cw-1:0] c_slot_last  = c_cw'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_cw-1:0] r_cnt;
  logic            r_snap_en;

  logic [2:0] w_nidx;
  logic [3:0] w_nib;
  logic       w_lz;
  logic       w_en;
  logic       w_dp;

  function automatic logic [6:0] f_hex7(input logic [3:0] n);
    case (n)
      4'h0: f_hex7 = 7'b0000001;
      4'h1: f_hex7 = 7'b1001111;
      4'h2: f_hex7 = 7'b0010010;
      4'h3: f_hex7 = 7'b0000110;
      4'h4: f_hex7 = 7'b1001100;
      4'h5: f_hex7 = 7'b0100100;
      4'h6: f_hex7 = 7'b0100000;
      4'h7: f_hex7 = 7'b0001111;
      4'h8: f_hex7 = 7'b0000000;
      4'h9: f_hex7 = 7'b0000100;
      4'hA: f_hex7 = 7'b0001000;
      4'hB: f_hex7 = 7'b1100000;
      4'hC: f_hex7 = 7'b0110001;
      4'hD: f_hex7 = 7'b1000010;
      4'hE: f_hex7 = 7'b0110000;
      default: f_hex7 = 7'b0111000;
    endcase
  endfunction

  // Snapshot source: the digit that owns the slot about to start.
  always_comb begin
    w_nidx = (r_state == S_SHOW) ? digit_idx + 3'd1 : 3'd0;
    w_nib  = digits[{w_nidx, 2'b00} +: 4];
    w_lz   = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    w_lz   = (w_nidx != 3'd0) && ((digits >> {w_nidx, 2'b00}) == 32'h0);
`endif
    w_en   = digit_en[w_nidx] & ~w_lz;
    w_dp   = dp_in[w_nidx] & ~w_lz;
  end

  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_snap_en  <= 1'b0;
      digit_idx  <= 3'd0;
      E          <= 8'hFF;
      CA2G       <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state   <= S_BLANK;
          r_cnt     <= '0;
          digit_idx <= 3'd0;
          r_snap_en <= w_en;
          E         <= 8'hFF;
          CA2G      <= f_hex7(w_nib);
          dp        <= ~w_dp;
        end
        S_BLANK: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_blank_last) begin
            r_state <= S_SHOW;
            E       <= r_snap_en ? ~(8'd1 << digit_idx) : 8'hFF;
          end
        end
        S_SHOW: begin
          if (r_cnt == c_slot_last) begin
            r_state    <= S_BLANK;
            r_cnt      <= '0;
            digit_idx  <= w_nidx;
            r_snap_en  <= w_en;
            E          <= 8'hFF;
            CA2G       <= f_hex7(w_nib);
            dp         <= ~w_dp;
            frame_tick <= (digit_idx == 3'd7);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_controller.sv
// ============================================================================
// Module      : tb_seg_scan_controller
// Description : Directed and random stimulus for seg_scan_controller, checked
//               against a slot-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_controller;

  localparam int c_div   = 8;
  localparam int c_blank = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [31:0] digits = 32'h0;
  logic [7:0]  digit_en = 8'hFF;
  logic [7:0]  dp_in = 8'h00;
  logic [7:0]  E;
  logic [6:0]  CA2G;
  logic        dp;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seg_scan_controller #(.REFRESH_DIV(c_div), .BLANK_CYCLES(c_blank)) dut (
    .clk(clk), .reset(reset), .en(en), .digits(digits), .digit_en(digit_en),
    .dp_in(dp_in), .E(E), .CA2G(CA2G), .dp(dp), .digit_idx(digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model: time since scan start, plus what was latched at the current slot start.
  bit         m_act = 0;
  int         m_t = 0;
  logic [3:0] m_nib;
  bit         m_den, m_dp;

  task automatic take(input int idx);
    bit lz;
    lz = 0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lz = (idx != 0) && ((digits >> (4 * idx)) == 32'h0);
`endif
    m_nib = digits[4*idx +: 4];
    m_den = digit_en[idx] && !lz;
    m_dp  = dp_in[idx] && !lz;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int idx, pos;
    logic [7:0] e_E;
    @(posedge clk);
    if (!reset || !en) m_act = 0;
    else if (!m_act) begin
      m_act = 1; m_t = 0; take(0);
    end else begin
      m_t++;
      if (m_t % c_div == 0) take((m_t / c_div) % 8);
    end
    #1;
    if (!m_act) begin
      chk("E_idle", E, 8'hFF);
      chk("CA2G_idle", CA2G, 7'h7F);
      chk("dp_idle", dp, 1'b1);
      chk("idx_idle", digit_idx, 3'd0);
      chk("tick_idle", frame_tick, 1'b0);
    end else begin
      idx = (m_t / c_div) % 8;
      pos = m_t % c_div;
      e_E = 8'hFF;
      if (pos >= c_blank && m_den) e_E[idx] = 1'b0;
      chk("E", E, e_E);
      chk("CA2G", CA2G, seg_tab[m_nib]);
      chk("dp", dp, !m_dp);
      chk("idx", digit_idx, idx[2:0]);
      chk("tick", frame_tick, (m_t > 0) && (m_t % (8 * c_div) == 0));
    end
    chk("one_anode", ($countones(~E) <= 1), 1'b1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held with en high
    reset = 1'b0; en = 1'b1;
    run(3);
    // Basic scan over a full frame and a bit
    reset = 1'b1; digits = 32'h76543210; digit_en = 8'hFF; dp_in = 8'h00;
    run(70);
    // Disabled digit 2, dp on digit 1
    digit_en = 8'hFB; dp_in = 8'h02;
    run(66);
    // Mid-slot update in slot 0
    en = 1'b0; digits = 32'h0; digit_en = 8'hFF; dp_in = 8'h00;
    step();
    en = 1'b1;
    run(4);
    digits = 32'hFFFFFFFF;
    run(14);
    // Enable drop during slot 3 SHOW, then restart
    en = 1'b0; step(); en = 1'b1;
    run(3 * c_div + 4);
    en = 1'b0; step(); step();
    en = 1'b1;
    run(12);
    // Leading-zero pattern
    en = 1'b0; digits = 32'h00000A05; digit_en = 8'hFF; step();
    en = 1'b1;
    run(70);
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) digits = $urandom >> $urandom_range(0, 32);
      if ($urandom_range(0, 31) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 31) == 0) dp_in = 8'($urandom);
      en    = ($urandom_range(0, 299) != 0);
      reset = ($urandom_range(0, 799) != 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
